// File: rtl/ddr3_pkg.sv
// Shared DDR3 command encodings, violation codes and state typedefs
// used by the responder and by controller-side benches.
package ddr3_pkg;

  localparam int BA_W   = 3;
  localparam int ADDR_W = 15;
  localparam int DQ_W   = 16;

  // {RAS,CAS,WE} while CS is low
  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_ZQ  = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_ACT_OPEN  = 3'd1,
    ERR_CLOSED    = 3'd2,
    ERR_TRCD      = 3'd3,
    ERR_TRP       = 3'd4,
    ERR_REFRESH   = 3'd5,
    ERR_BANK_OPEN = 3'd6
  } err_e;

  typedef enum logic {BANK_CLOSED = 1'b0, BANK_OPEN = 1'b1} bank_st_e;
  typedef enum logic {DEV_READY = 1'b0, DEV_REFRESH = 1'b1} dev_st_e;

  function automatic cmd_e decode(input logic cs, input logic ras,
                                  input logic cas, input logic we);
    return cs ? CMD_NOP : cmd_e'({ras, cas, we});
  endfunction

endpackage

// File: rtl/ddr3_cmd_responder_if.sv
// DDR3 command/data pins between a controller (master) and the
// responder (slave), plus the responder's status outputs.
interface ddr3_cmd_responder_if #(
  parameter int NUM_BANKS = 8
);
  import ddr3_pkg::*;

  logic                   CS, RAS, CAS, WE;
  logic [ADDR_W-1:0]      Addr;
  logic [BA_W-1:0]        BA;
  logic                   LDM, UDM;
  logic [DQ_W-1:0]        DQ_in;
  logic [DQ_W-1:0]        DQ_out;
  logic                   DQ_oe, LDQS, UDQS;
  logic [NUM_BANKS-1:0]   bank_open;
  logic                   err;
  logic [2:0]             err_code;

  modport master (
    output CS, RAS, CAS, WE, Addr, BA, LDM, UDM, DQ_in,
    input  DQ_out, DQ_oe, LDQS, UDQS, bank_open, err, err_code
  );

  modport slave (
    input  CS, RAS, CAS, WE, Addr, BA, LDM, UDM, DQ_in,
    output DQ_out, DQ_oe, LDQS, UDQS, bank_open, err, err_code
  );

endinterface

// File: rtl/ddr3_read_pipe.sv
// Fixed-latency valid+data shift register; flush clears only the
// valid bits, data lanes are don't-care when invalid.
module ddr3_read_pipe #(
  parameter int DEPTH = 5,
  parameter int W     = 16
) (
  input  logic         clk_i,
  input  logic         flush_i,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic [DEPTH-1:0]        vld_pipe;
  logic [DEPTH-1:0][W-1:0] dat_pipe;

  always_ff @(posedge clk_i) begin
    if (flush_i) vld_pipe <= '0;
    else         vld_pipe <= {vld_pipe[DEPTH-2:0], vld_i};
  end

  always_ff @(posedge clk_i) begin
    dat_pipe <= {dat_pipe[DEPTH-2:0], data_i};
  end

  assign vld_o  = vld_pipe[DEPTH-1];
  assign data_o = dat_pipe[DEPTH-1];

endmodule

// File: rtl/ddr3_cmd_responder.sv
// DDR3 device-side responder: decodes commands, tracks bank/refresh
// timing, stores write data, returns reads after CL, flags violations.
module ddr3_cmd_responder
  import ddr3_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int CL        = 5,
  parameter int T_RCD     = 4,
  parameter int T_RP      = 4,
  parameter int T_RFC     = 10,
  parameter int ROW_SEL   = 2,
  parameter int COL_SEL   = 3
) (
  input  logic                 CLK,
  input  logic                 RESET,
  ddr3_cmd_responder_if.slave  bus
);

  localparam int CNT_W  = $clog2(((T_RCD > T_RP) ? T_RCD : T_RP) + 1);
  localparam int RFC_W  = $clog2(T_RFC + 1);
  localparam int MEM_AW = BA_W + ROW_SEL + COL_SEL;

  cmd_e                              cmd;
  err_e                              viol;
  logic                              accept, busy, a10, ref_go;
  logic                              act_go, rd_go, wr_go;
  logic [BA_W-1:0]                   ba;
  bank_st_e [NUM_BANKS-1:0]          bank_q, bank_d;
  logic [NUM_BANKS-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_BANKS-1:0][ROW_SEL-1:0] row_q;
  logic                              err_q, err_d;
  logic [2:0]                        err_code_q, err_code_d;
  dev_st_e                           dev_q, dev_d;
  logic [RFC_W-1:0]                  rfc_q, rfc_d;
  logic [DQ_W-1:0]                   mem [2**MEM_AW];
  logic [MEM_AW-1:0]                 maddr;
  logic [DQ_W-1:0]                   rd_data, pipe_dat, dq_out_q;
  logic                              pipe_vld, dq_oe_q;
  logic                              unused_addr;

  assign cmd         = decode(bus.CS, bus.RAS, bus.CAS, bus.WE);
  assign ba          = bus.BA;
  assign a10         = bus.Addr[10];
  assign maddr       = {ba, row_q[ba], bus.Addr[COL_SEL-1:0]};
  assign unused_addr = ^bus.Addr;

  // Refresh lockout takes priority over every per-command check
  always_comb begin
    viol = ERR_NONE;
    if (busy && cmd != CMD_NOP) viol = ERR_REFRESH;
    else begin
      case (cmd)
        CMD_ACT:
          if (bank_q[ba] == BANK_OPEN) viol = ERR_ACT_OPEN;
          else if (cnt_q[ba] != '0)    viol = ERR_TRP;
        CMD_RD, CMD_WR:
          if (bank_q[ba] == BANK_CLOSED) viol = ERR_CLOSED;
          else if (cnt_q[ba] != '0)      viol = ERR_TRCD;
        CMD_REF, CMD_MRS, CMD_ZQ:
          for (int b = 0; b < NUM_BANKS; b++)
            if (bank_q[b] == BANK_OPEN) viol = ERR_BANK_OPEN;
        default: ;
      endcase
    end
  end

  assign accept = (viol == ERR_NONE);
  assign ref_go = accept && cmd == CMD_REF;
  assign act_go = accept && cmd == CMD_ACT && !RESET;
  assign rd_go  = accept && cmd == CMD_RD  && !RESET;
  assign wr_go  = accept && cmd == CMD_WR  && !RESET;

  // An open bank's counter is tRCD, a closed bank's counter is tRP
  always_comb begin
    bank_d = bank_q;
    cnt_d  = cnt_q;
    for (int b = 0; b < NUM_BANKS; b++)
      if (cnt_q[b] != '0) cnt_d[b] = cnt_q[b] - 1'b1;
    if (accept) begin
      case (cmd)
        CMD_ACT: begin
          bank_d[ba] = BANK_OPEN;
          cnt_d[ba]  = CNT_W'(T_RCD - 1);
        end
        CMD_RD, CMD_WR:
          if (a10) begin
            bank_d[ba] = BANK_CLOSED;
            cnt_d[ba]  = CNT_W'(T_RP - 1);
          end
        CMD_PRE:
          for (int b = 0; b < NUM_BANKS; b++)
            if (bank_q[b] == BANK_OPEN && (a10 || ba == BA_W'(b))) begin
              bank_d[b] = BANK_CLOSED;
              cnt_d[b]  = CNT_W'(T_RP - 1);
            end
        default: ;
      endcase
    end
    err_d      = err_q | !accept;
    err_code_d = (!err_q && !accept) ? viol : err_code_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int b = 0; b < NUM_BANKS; b++) bank_q[b] <= BANK_CLOSED;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      bank_q     <= bank_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Device FSM: state register / next state / output
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dev_q <= DEV_READY;
      rfc_q <= '0;
    end else begin
      dev_q <= dev_d;
      rfc_q <= rfc_d;
    end
  end

  always_comb begin
    dev_d = dev_q;
    rfc_d = (rfc_q != '0) ? rfc_q - 1'b1 : rfc_q;
    case (dev_q)
      DEV_READY:   if (ref_go) dev_d = DEV_REFRESH;
      DEV_REFRESH: if (!ref_go && rfc_q == '0) dev_d = DEV_READY;
      default: ;
    endcase
    if (ref_go) rfc_d = RFC_W'(T_RFC - 1);
  end

  always_comb busy = (dev_q == DEV_REFRESH) && (rfc_q != '0);

  always_ff @(posedge CLK) begin
    if (act_go) row_q[ba] <= bus.Addr[ROW_SEL-1:0];
  end

  always_ff @(posedge CLK) begin
    if (wr_go) begin
      if (!bus.LDM) mem[maddr][7:0]  <= bus.DQ_in[7:0];
      if (!bus.UDM) mem[maddr][15:8] <= bus.DQ_in[15:8];
    end
  end

  assign rd_data = mem[maddr];

  ddr3_read_pipe #(.DEPTH(CL), .W(DQ_W)) u_rd_pipe (
    .clk_i   (CLK),
    .flush_i (RESET),
    .vld_i   (rd_go),
    .data_i  (rd_data),
    .vld_o   (pipe_vld),
    .data_o  (pipe_dat)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else begin
      dq_oe_q  <= pipe_vld;
      dq_out_q <= pipe_vld ? pipe_dat : '0;
    end
  end

  assign bus.DQ_out   = dq_out_q;
  assign bus.DQ_oe    = dq_oe_q;
  assign bus.LDQS     = dq_oe_q;
  assign bus.UDQS     = dq_oe_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_open
    assign bus.bank_open[b] = (bank_q[b] == BANK_OPEN);
  end

endmodule
